// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the fifo_drain read-side drainer.
package fifo_drain_pkg;

  localparam int unsigned OBUF_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned STATS_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] RUN   = S_RUN;
  localparam logic [1:0] FLUSH = S_FLUSH;

endpackage

// File: rtl/fifo_drain_obuf.sv
// Two-entry ordered output buffer; head is registered and drives the stream directly.
module fifo_drain_obuf
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DW-1:0]    din,
  input  logic             pop,
  output logic [CNT_W-1:0] cnt,
  output logic [DW-1:0]    head
);

  logic [DW-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == CNT_W'(0)) head <= din;
          else                  tail <= din;
          cnt <= cnt + CNT_W'(1);
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - CNT_W'(1);
        end
        // simultaneous push and pop: count holds, entries shift
        2'b11: begin
          if (cnt == CNT_W'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt == CNT_W'(OBUF_DEPTH)));

endmodule

// File: rtl/fifo_drain.sv
// Drains a FIFO with write-priority read refusal into a ready/valid stream.
// Optional FIFO_DRAIN_STATS_EN adds a 16-bit delivered-beat counter output.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic          fifo_wr,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [STATS_W-1:0] beat_cnt
`endif
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             pend;
  logic [CNT_W-1:0] obuf_cnt;
  logic             pop;
  logic             rd_acc;
  logic [2:0]       occ;
  logic [2:0]       left_after_pop;

  assign pop            = m_valid & m_ready;
  // words that will sit in the buffer after this edge if no new read lands
  assign occ            = 3'(obuf_cnt) + 3'(pend) - 3'(pop);
  assign left_after_pop = 3'(obuf_cnt) - 3'(pop);

  assign fifo_rd = ~rst & (state == RUN) & ~fifo_empty & (occ < 3'd2);
  assign rd_acc  = fifo_rd & ~fifo_empty & ~(fifo_wr & ~fifo_full);
  assign m_valid = (obuf_cnt != CNT_W'(0));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= rd_acc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN: begin
        if (!en) begin
          if (pend || obuf_cnt != CNT_W'(0)) state_nxt = FLUSH;
          else                               state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (en)                                    state_nxt = RUN;
        else if (!pend && left_after_pop == 3'd0)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // registered FIFO data is valid the cycle after an accepted read
  fifo_drain_obuf #(.DW(DW)) u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (pend),
    .din  (fifo_dout),
    .pop  (pop),
    .cnt  (obuf_cnt),
    .head (m_data)
  );

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)      beat_cnt <= '0;
    else if (pop) beat_cnt <= beat_cnt + STATS_W'(1);
  end
`endif

endmodule
